// File: rtl/wb_unit_pkg.sv
// Shared write-back definitions: widths, result-select and load-type codes.
// Optional misaligned-load trap is enabled with WB_MISALIGN_CHK_EN.
package wb_unit_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int WB_SEL_WIDTH   = 2;
  localparam int LD_TYPE_WIDTH  = 3;

  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_NONE = 2'd3;

  localparam logic [LD_TYPE_WIDTH-1:0] LD_LB  = 3'd0;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LH  = 3'd1;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LW  = 3'd2;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LBU = 3'd4;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LHU = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [LD_TYPE_WIDTH-1:0]  ld_type;
    logic [1:0]                off;
  } ld_req_t;

  function automatic logic is_misaligned(
    input logic [LD_TYPE_WIDTH-1:0] ld_type,
    input logic [1:0]               off
  );
    logic half;
    half = (ld_type == LD_LH) || (ld_type == LD_LHU);
    return (half && off[0]) ||
           ((ld_type == LD_LW) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/wb_unit_ld_extend.sv
// Load data lane select and sign/zero extension.
// Purely combinational; unknown load types pass the word through.
module ld_extend
  import wb_unit_pkg::*;
(
  input  logic [LD_TYPE_WIDTH-1:0] ld_type,
  input  logic [1:0]               addr,
  input  logic [CPU_WIDTH-1:0]     rdata,
  output logic [CPU_WIDTH-1:0]     wdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[7:0];
    unique case (addr)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
    endcase
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = rdata;
    unique case (1'b1)
      (ld_type == LD_LB):
        wdata = {{(CPU_WIDTH-8){lane_b[7]}}, lane_b};
      (ld_type == LD_LBU):
        wdata = {{(CPU_WIDTH-8){1'b0}}, lane_b};
      (ld_type == LD_LH):
        wdata = {{(CPU_WIDTH-16){lane_h[15]}}, lane_h};
      (ld_type == LD_LHU):
        wdata = {{(CPU_WIDTH-16){1'b0}}, lane_h};
      default:
        wdata = rdata;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: ALU/PC+4 results and blocking loads with timeout.
// Define WB_MISALIGN_CHK_EN to trap misaligned LH/LHU/LW loads.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [WB_SEL_WIDTH-1:0]   ex_wb_sel,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [CPU_WIDTH-1:0]      ex_alu_res,
  input  logic [CPU_WIDTH-1:0]      ex_pc,
  input  logic [LD_TYPE_WIDTH-1:0]  ex_ld_type,
  input  logic                      dmem_rvalid,
  input  logic [CPU_WIDTH-1:0]      dmem_rdata,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [CPU_WIDTH-1:0]      reg_wdata,
  output logic                      timeout_err
`ifdef WB_MISALIGN_CHK_EN
  ,
  output logic                      misalign_err
`endif
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1
                    : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  wb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ld_req_t req_q, req_d;

  logic                      wr_req;
  logic [REG_ADDR_WIDTH-1:0] wr_rd;
  logic [CPU_WIDTH-1:0]      wr_data;
  logic                      wen_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_d;
  logic [CPU_WIDTH-1:0]      wdata_d;
  logic                      to_d;
  logic [CPU_WIDTH-1:0]      ext_data;
`ifdef WB_MISALIGN_CHK_EN
  logic                      mis_d;
`endif

  assign ex_ready = (state_q == S_IDLE);

  ld_extend u_ld_extend (
    .ld_type (req_q.ld_type),
    .addr    (req_q.off),
    .rdata   (dmem_rdata),
    .wdata   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    wr_req  = 1'b0;
    wr_rd   = '0;
    wr_data = '0;
    to_d    = 1'b0;
`ifdef WB_MISALIGN_CHK_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          unique case (1'b1)
            (ex_wb_sel == WB_SEL_ALU): begin
              wr_req  = 1'b1;
              wr_rd   = ex_rd;
              wr_data = ex_alu_res;
            end
            (ex_wb_sel == WB_SEL_PC4): begin
              wr_req  = 1'b1;
              wr_rd   = ex_rd;
              wr_data = ex_pc + CPU_WIDTH'(4);
            end
            (ex_wb_sel == WB_SEL_MEM): begin
`ifdef WB_MISALIGN_CHK_EN
              if (is_misaligned(ex_ld_type, ex_alu_res[1:0]))
                mis_d = 1'b1;
              else
`endif
              begin
                state_d       = S_WAIT;
                cnt_d         = '0;
                req_d.rd      = ex_rd;
                req_d.ld_type = ex_ld_type;
                req_d.off     = ex_alu_res[1:0];
              end
            end
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        // a response on the last allowed cycle still completes the load
        if (dmem_rvalid) begin
          state_d = S_IDLE;
          wr_req  = 1'b1;
          wr_rd   = req_q.rd;
          wr_data = ext_data;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = reg_waddr;
    wdata_d = reg_wdata;
    if (wr_req && (wr_rd != '0)) begin
      wen_d   = 1'b1;
      waddr_d = wr_rd;
      wdata_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      reg_wen     <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      reg_wen     <= wen_d;
      reg_waddr   <= waddr_d;
      reg_wdata   <= wdata_d;
      timeout_err <= to_d;
    end
  end

`ifdef WB_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)
      misalign_err <= 1'b0;
    else
      misalign_err <= mis_d;
  end
`endif

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, sets how many WAIT cycles may pass with no dmem_rvalid before the load is abandoned.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ex_valid  input  1  EX stage presents an instruction for write-back.
REQ-005 ex_ready  output  1  unit accepts ex_valid this cycle.
REQ-006 ex_wb_sel  input  WB_SEL_WIDTH(2)  result source: ALU, MEM, PC4 or NONE.
REQ-007 ex_rd  input  REG_ADDR_WIDTH(5)  destination register index.
REQ-008 ex_alu_res  input  CPU_WIDTH  ALU result, which is also the load address.
REQ-009 ex_pc  input  CPU_WIDTH  PC of the instruction.
REQ-010 ex_ld_type  input  LD_TYPE_WIDTH(3)  load type: LB, LH, LW, LBU or LHU.
REQ-011 dmem_rvalid / dmem_rdata  input  1 / CPU_WIDTH  data-memory read response (aligned word).
REQ-012 reg_wen / reg_waddr / reg_wdata  output  1 / 5 / CPU_WIDTH  register-file write port.
REQ-013 timeout_err  output  1  one-cycle pulse: load abandoned.
REQ-014 misalign_err  output  1  one-cycle pulse: misaligned load (present only with the REQ-031 macro).

Function
REQ-015 States SHALL be IDLE and WAIT; ex_ready SHALL be 1 in IDLE and 0 in WAIT, decoded from the state register only.
REQ-016 In IDLE, for ex_valid with sel=ALU, the unit SHALL, on the next cycle, assert reg_wen for exactly one cycle with reg_waddr=ex_rd and reg_wdata=ex_alu_res.
REQ-017 In IDLE, for ex_valid with sel=PC4, the unit SHALL do the same with reg_wdata=ex_pc+4; the sum SHALL wrap modulo 2^CPU_WIDTH.
REQ-018 In IDLE, for ex_valid with sel=NONE, the unit SHALL not write and SHALL stay in IDLE.
REQ-019 In IDLE, for ex_valid with sel=MEM, the unit SHALL capture rd, ld_type and ex_alu_res[1:0], clear the wait counter and enter WAIT.
REQ-020 In WAIT, the cycle dmem_rvalid=1 is sampled, the unit SHALL return to IDLE and assert reg_wen on the next cycle with the extracted data.
REQ-021 Extraction: LB/LBU SHALL take byte addr[1:0], sign-/zero-extended; LH/LHU SHALL take half addr[1], sign-/zero-extended; LW SHALL take the full word.
REQ-022 In WAIT, the wait counter SHALL increment each cycle with no rvalid; when it reaches TIMEOUT_CYCLES, the unit SHALL pulse timeout_err for one cycle, not write, and return to IDLE.
REQ-023 When rvalid and the timeout coincide, rvalid SHALL win: data written, no error.
REQ-024 When rd=0, reg_wen SHALL stay 0, but all state transitions SHALL be unchanged.
REQ-025 dmem_rvalid in IDLE SHALL be ignored; ex_valid in WAIT SHALL be ignored.
REQ-026 reg_wen, reg_waddr and reg_wdata SHALL be registered, with latency of exactly one cycle after the triggering event; reg_waddr and reg_wdata SHALL hold their last values when reg_wen=0.

Reset
REQ-027 On rst=1 at a clock edge, state SHALL become IDLE and the counter 0.
REQ-028 On rst=1 at a clock edge, reg_wen, reg_waddr, reg_wdata, timeout_err and misalign_err SHALL become 0.
REQ-029 Reset during WAIT SHALL abandon the load silently, with no error pulse and no write; ex_ready SHALL be 1 on the cycle after reset is released.
REQ-030 Reset SHALL take priority over every other input.

Configuration
REQ-031 With WB_MISALIGN_CHK_EN defined, an IDLE MEM load that is LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, SHALL not enter WAIT, SHALL pulse misalign_err the next cycle, and SHALL not write.
REQ-032 Without WB_MISALIGN_CHK_EN, the misalign_err port SHALL not exist and misaligned loads SHALL proceed as in REQ-021: LW ignores addr[1:0], LH ignores addr[0].

Structure
REQ-033 WB_SEL_* codes (ALU=0, MEM=1, PC4=2, NONE=3), LD_* codes, their widths, CPU_WIDTH and REG_ADDR_WIDTH SHALL live in the shared defines file.
REQ-034 Byte/half select and extension SHALL be a combinational sub-module, ld_extend, with inputs ld_type, addr[1:0] and rdata and output wdata.

Verification
REQ-035 ALU case: IDLE, sel=ALU, rd=5, alu_res=0x1234_5678 -> next cycle reg_wen=1, waddr=5, wdata=0x1234_5678, then reg_wen=0.
REQ-036 PC4 wrap case: sel=PC4, pc=0xFFFF_FFFC, rd=1 -> wdata=0x0000_0000.
REQ-037 LB case: LB at addr=...3, rdata=0x80AA_BBCC, rvalid 3 cycles later -> ex_ready=0 for those cycles, then wdata=0xFFFF_FF80; LBU with the same data -> 0x0000_0080.
REQ-038 Timeout case: MEM load with TIMEOUT_CYCLES=4 and no rvalid -> timeout_err pulses once, no reg_wen, ex_ready=1 the following cycle.
REQ-039 Misaligned case: with the macro defined, LW at addr=0x102 -> misalign_err pulse, no WAIT; without the macro -> wait completes and the full word is written.
REQ-040 Reset case: rst asserted during WAIT together with rvalid -> no write, no error pulse, outputs 0; rd=0 ALU case -> reg_wen stays 0.
